// File: rtl/dcache_bus_arb_pkg.sv
// Shared definitions for the Dcache coherence bus: message encoding,
// address field widths and the line-address helper used by the arbiter.
package dcache_bus_arb_pkg;

  localparam int DCACHE_TAG_W        = 55;
  localparam int DCACHE_IDX_W        = 6;
  localparam int DCACHE_WORD_IN_BITS = 64;
  localparam int MSG_W               = 2;

  typedef enum logic [MSG_W-1:0] {
    NONE  = 2'd0,
    GET_S = 2'd1,
    GET_M = 2'd2,
    PUT_M = 2'd3
  } message_t;

  // Memory address of a cache line: tag and index above the 8-byte word offset.
  function automatic logic [63:0] line_addr(input logic [DCACHE_TAG_W-1:0] tag,
                                            input logic [DCACHE_IDX_W-1:0] idx);
    return {tag, idx, 3'b000};
  endfunction

endpackage

// File: rtl/dcache_bus_rr_arb.sv
// Two-way round-robin arbiter. A lone requester always wins; when both
// request, the core that did not win last time gets the grant.
module dcache_bus_rr_arb
  import dcache_bus_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update_en,
  output logic [1:0] grant
);

  // last_grant = 1 means core 1 won last, so core 0 wins the first tie.
  logic last_grant;

  // Combinational one-hot grant from the pending requests and history.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Remember the winner whenever a grant is actually taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (update_en && (|grant)) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/dcache_bus_arb.sv
// Coherence bus arbiter shared by the two core Dcaches and main memory.
// Grants one request at a time, broadcasts it for snooping, sources data
// from the peer cache or memory and holds the response until acked.
// Optional watchdog: define DCACHE_BUS_WDOG_EN to enable bus_err_o.
module dcache_bus_arb
  import dcache_bus_arb_pkg::*;
#(
  parameter int WDOG_LIMIT = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    dc_req_en_i,
  input  logic [1:0][DCACHE_TAG_W-1:0]  dc_req_tag_i,
  input  logic [1:0][DCACHE_IDX_W-1:0]  dc_req_idx_i,
  input  logic [1:0][63:0]              dc_req_data_i,
  input  logic [1:0][MSG_W-1:0]         dc_req_msg_i,
  input  logic [1:0]                    dc_rsp_vld_i,
  input  logic [1:0][63:0]              dc_rsp_data_i,
  input  logic [1:0]                    dc_rsp_ack_i,
  output logic [1:0]                    bus_req_ack_o,
  output logic                          bus_req_id_o,
  output logic [DCACHE_TAG_W-1:0]       bus_req_tag_o,
  output logic [DCACHE_IDX_W-1:0]       bus_req_idx_o,
  output message_t                      bus_req_msg_o,
  output logic                          bus_rsp_vld_o,
  output logic                          bus_rsp_id_o,
  output logic [63:0]                   bus_rsp_data_o,
  output logic                          mem_req_en_o,
  output logic                          mem_req_wr_o,
  output logic [63:0]                   mem_req_addr_o,
  output logic [63:0]                   mem_req_data_o,
  input  logic                          mem_req_ack_i,
  input  logic                          mem_rsp_vld_i,
  input  logic [63:0]                   mem_rsp_data_i,
  output logic                          bus_err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_BCAST, S_SNOOP, S_MEM_REQ, S_MEM_WAIT, S_RSP
  } arb_state_t;

  arb_state_t  state;
  logic [1:0]  grant;
  logic [63:0] req_data;

  dcache_bus_rr_arb u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (dc_req_en_i),
    .update_en (state == S_IDLE),
    .grant     (grant)
  );

  // Writeback payload captured at grant; only meaningful for PUT_M.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && (|grant)) begin
      req_data <= dc_req_data_i[grant[1]];
    end
  end

`ifdef DCACHE_BUS_WDOG_EN
  logic [7:0] wdog_cnt;
  logic       wdog_state;
  logic       wdog_leave;
  logic       wdog_hit;

  // Which states are timed, and whether the current one is being left this cycle.
  always_comb begin
    wdog_state = state inside {S_MEM_REQ, S_MEM_WAIT, S_RSP};
    wdog_leave = 1'b0;
    case (state)
      S_MEM_REQ:  wdog_leave = mem_req_ack_i;
      S_MEM_WAIT: wdog_leave = mem_rsp_vld_i;
      S_RSP:      wdog_leave = dc_rsp_ack_i[bus_rsp_id_o];
      default:    wdog_leave = 1'b0;
    endcase
  end

  assign wdog_hit = wdog_state && !wdog_leave && (wdog_cnt == 8'(WDOG_LIMIT - 1));

  // Cycles spent in the current timed state; error is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt  <= 8'd0;
      bus_err_o <= 1'b0;
    end else begin
      if (!wdog_state || wdog_leave || wdog_hit) wdog_cnt <= 8'd0;
      else                                       wdog_cnt <= wdog_cnt + 8'd1;
      if (wdog_hit) bus_err_o <= 1'b1;
    end
  end
`else
  assign bus_err_o = 1'b0;
`endif

  // Transaction FSM with registered bus and memory outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      bus_req_ack_o  <= 2'b00;
      bus_req_id_o   <= 1'b0;
      bus_req_tag_o  <= '0;
      bus_req_idx_o  <= '0;
      bus_req_msg_o  <= NONE;
      bus_rsp_vld_o  <= 1'b0;
      bus_rsp_id_o   <= 1'b0;
      bus_rsp_data_o <= '0;
      mem_req_en_o   <= 1'b0;
      mem_req_wr_o   <= 1'b0;
      mem_req_addr_o <= '0;
      mem_req_data_o <= '0;
    end else begin
      bus_req_ack_o <= 2'b00;
      case (state)
        S_IDLE: begin
          if (|grant) begin
            state         <= S_BCAST;
            bus_req_ack_o <= grant;
            bus_req_id_o  <= grant[1];
            bus_req_tag_o <= dc_req_tag_i[grant[1]];
            bus_req_idx_o <= dc_req_idx_i[grant[1]];
            bus_req_msg_o <= message_t'(dc_req_msg_i[grant[1]]);
          end
        end
        S_BCAST: begin
          bus_req_msg_o <= NONE;
          if (bus_req_msg_o == PUT_M) begin
            state          <= S_MEM_REQ;
            mem_req_en_o   <= 1'b1;
            mem_req_wr_o   <= 1'b1;
            mem_req_addr_o <= line_addr(bus_req_tag_o, bus_req_idx_o);
            mem_req_data_o <= req_data;
          end else begin
            state <= S_SNOOP;
          end
        end
        S_SNOOP: begin
          if (dc_rsp_vld_i[~bus_req_id_o]) begin
            state          <= S_RSP;
            bus_rsp_vld_o  <= 1'b1;
            bus_rsp_id_o   <= bus_req_id_o;
            bus_rsp_data_o <= dc_rsp_data_i[~bus_req_id_o];
          end else begin
            state          <= S_MEM_REQ;
            mem_req_en_o   <= 1'b1;
            mem_req_wr_o   <= 1'b0;
            mem_req_addr_o <= line_addr(bus_req_tag_o, bus_req_idx_o);
          end
        end
        S_MEM_REQ: begin
          if (mem_req_ack_i) begin
            mem_req_en_o <= 1'b0;
            mem_req_wr_o <= 1'b0;
            state        <= mem_req_wr_o ? S_IDLE : S_MEM_WAIT;
          end
        end
        S_MEM_WAIT: begin
          if (mem_rsp_vld_i) begin
            state          <= S_RSP;
            bus_rsp_vld_o  <= 1'b1;
            bus_rsp_id_o   <= bus_req_id_o;
            bus_rsp_data_o <= mem_rsp_data_i;
          end
        end
        S_RSP: begin
          if (dc_rsp_ack_i[bus_rsp_id_o]) begin
            state         <= S_IDLE;
            bus_rsp_vld_o <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
`ifdef DCACHE_BUS_WDOG_EN
      if (wdog_hit) begin
        state         <= S_IDLE;
        mem_req_en_o  <= 1'b0;
        mem_req_wr_o  <= 1'b0;
        bus_rsp_vld_o <= 1'b0;
      end
`endif
    end
  end

endmodule
